cordic_range_reduce: RTL and testbench

Upstream argument-reduction stage for cordic_cos. It accepts an arbitrary signed fixed-point angle in radians and reduces it to theta in [0, pi/2], which lies inside the CORDIC convergence range. It also outputs a negate flag; the consumer negates cos_out when the flag is 1. Reduction is iterative, one restoring mod-2pi step per cycle, with valid/ready handshakes on both sides.

---
 rtl/cordic_pkg.sv | 8 +
 rtl/cordic_range_reduce.sv | 66 ++++++
 tb/tb_cordic_range_reduce.sv | 118 +++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared Q.20 angle constants and reduction FSM states for the cordic blocks
package cordic_pkg;
    localparam int C_W = 23;
    localparam logic [C_W-1:0] TWO_PI_C  = 23'h6487ED;
    localparam logic [C_W-1:0] PI_C      = 23'h3243F7;
    localparam logic [C_W-1:0] HALF_PI_C = 23'h1921FB;
    typedef enum logic [1:0] {IDLE, REDUCE, FOLD, DONE} state_t;
endpackage

// File: rtl/cordic_range_reduce.sv
// cordic_range_reduce: folds any signed angle into [0, pi/2] plus a cosine negate flag
module cordic_range_reduce
    import cordic_pkg::*;
#(
    parameter int IN_W      = 32,
    parameter int FRAC_BITS = 20
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [IN_W-1:0]             angle_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [FRAC_BITS+1:0] theta_out,
    output logic                        neg_out
);
    localparam int STEPS = IN_W - FRAC_BITS - 3;
    localparam int K_W   = $clog2(STEPS);
    localparam logic [IN_W-1:0] TWO_PI_W = IN_W'(TWO_PI_C);
    state_t                 state;
    logic [IN_W-1:0]        r, sub, mag;
    logic [K_W-1:0]         k;
    logic [C_W-1:0]         r1;
    logic [FRAC_BITS+1:0]   fold_theta;
    logic                   fold_neg;
    always_comb begin
        mag        = angle_in[IN_W-1] ? -angle_in : angle_in;
        sub        = TWO_PI_W << k;
        // after REDUCE, r < 2*pi so its low C_W bits hold the whole remainder
        r1         = (r[C_W-1:0] > PI_C) ? TWO_PI_C - r[C_W-1:0] : r[C_W-1:0];
        fold_neg   = r1 > HALF_PI_C;
        fold_theta = fold_neg ? (FRAC_BITS+2)'(PI_C - r1) : (FRAC_BITS+2)'(r1);
    end
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            r         <= '0;
            k         <= '0;
            theta_out <= '0;
            neg_out   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    r     <= mag;
                    k     <= K_W'(STEPS - 1);
                    state <= REDUCE;
                end
                REDUCE: begin
                    if (r >= sub) r <= r - sub;
                    k <= k - 1'b1;
                    if (k == '0) state <= FOLD;
                end
                FOLD: begin
                    theta_out <= fold_theta;
                    neg_out   <= fold_neg;
                    state     <= DONE;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_range_reduce.sv
// tb_cordic_range_reduce: directed vector table plus backpressure and mid-reduce reset sequences
module tb_cordic_range_reduce;
    logic        clk = 0;
    logic        reset, in_valid, out_ready, in_ready, out_valid, neg_out;
    logic [31:0] angle_in;
    logic signed [21:0] theta_out;
    int passed = 0, total = 0;

    cordic_range_reduce dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .angle_in(angle_in), .out_valid(out_valid), .out_ready(out_ready),
        .theta_out(theta_out), .neg_out(neg_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] angle;
        logic [21:0] theta;
        logic        neg;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Accepts one angle and returns the accept-to-out_valid cycle count.
    task automatic send(input logic [31:0] a, output int lat, output logic busy_ok);
        int w = 0;
        while (!in_ready && w < 40) begin @(posedge clk); #1; w++; end
        chk("accept_wait", int'(in_ready), 1);
        in_valid = 1; angle_in = a;
        @(posedge clk); #1;
        in_valid = 0;
        lat = 0; busy_ok = 1;
        while (!out_valid && lat < 40) begin
            if (in_ready) busy_ok = 0;
            @(posedge clk); #1; lat++;
        end
    endtask

    vec_t vecs[5];
    int lat;
    logic busy_ok;
    logic [21:0] held_theta;
    logic held_neg;

    initial begin
        vecs[0] = '{32'h0000_0000, 22'h0, 1'b0};
        vecs[1] = '{32'h0032_43F7, 22'h0, 1'b1};
        vecs[2] = '{-32'sh0010_0000, 22'h10_0000, 1'b0};
        vecs[3] = '{32'h0020_0000, 22'd1197047, 1'b1};
        vecs[4] = '{32'h8000_0000, 22'd333774, 1'b0};
        // an exact multiple of 2*pi (3 * TWO_PI_C)
        // and r1 exactly pi/2 (pi/2 itself)

        reset = 1; in_valid = 0; out_ready = 1; angle_in = 0;
        repeat (2) @(posedge clk); #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_theta", longint'(theta_out), 0);
        chk("rst_neg", int'(neg_out), 0);
        reset = 0;

        for (int i = 0; i < 5; i++) begin
            send(vecs[i].angle, lat, busy_ok);
            chk($sformatf("v%0d_latency", i), lat, 10);
            chk($sformatf("v%0d_busy", i), int'(busy_ok), 1);
            chk($sformatf("v%0d_theta", i), longint'(theta_out), longint'(signed'(vecs[i].theta)));
            chk($sformatf("v%0d_neg", i), int'(neg_out), int'(vecs[i].neg));
            @(posedge clk); #1;
            chk($sformatf("v%0d_release", i), int'({out_valid, in_ready}), 1);
        end

        send(32'd19765191, lat, busy_ok);
        chk("mult2pi_theta", longint'(theta_out), 0);
        chk("mult2pi_neg", int'(neg_out), 0);
        @(posedge clk); #1;
        send(32'd1647099, lat, busy_ok);
        chk("halfpi_theta", longint'(theta_out), 1647099);
        chk("halfpi_neg", int'(neg_out), 0);
        @(posedge clk); #1;

        out_ready = 0;
        send(32'h0020_0000, lat, busy_ok);
        held_theta = theta_out; held_neg = neg_out;
        chk("bp_theta0", longint'(theta_out), 1197047);
        in_valid = 1; angle_in = 32'h0010_0000;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp%0d_stable", c),
                int'({out_valid, in_ready, neg_out, theta_out == signed'(held_theta)}),
                int'({1'b1, 1'b0, held_neg, 1'b1}));
        end
        out_ready = 1;
        @(posedge clk); #1;
        chk("bp_release", int'({out_valid, in_ready}), 1);
        @(posedge clk); #1;
        chk("next_accepted", int'(in_ready), 0);
        in_valid = 0;
        repeat (3) @(posedge clk); #1;
        chk("mid_reduce", int'({out_valid, in_ready}), 0);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        chk("rst2_in_ready", int'(in_ready), 1);
        chk("rst2_out_valid", int'(out_valid), 0);
        chk("rst2_theta", longint'(theta_out), 0);
        chk("rst2_neg", int'(neg_out), 0);
        repeat (12) @(posedge clk); #1;
        chk("rst2_no_result", int'(out_valid), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
